fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 10'd0: byte address loaded into the PC on reset.
REQ-002 Parameter HALT_WORD, default 32'hFFFFFFFF: instruction encoding that stops sequential fetch.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 address  output  10  byte address to the instruction memory; equals the PC register, combinational.
REQ-006 instruction  input  32  instruction word returned combinationally by the memory for address.
REQ-007 stall  input  1  freeze fetch when high.
REQ-008 branch_taken  input  1  redirect request, one-cycle pulse.
REQ-009 branch_target  input  10  redirect byte address; sampled when branch_taken=1.
REQ-010 out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-011 out_ready  input  1  downstream (decode) accepts the word when out_valid&out_ready.
REQ-012 out_instr  output  32  registered fetched instruction.
REQ-013 out_pc  output  10  byte address out_instr was fetched from.
REQ-014 halted  output  1  high while the FSM is in HALTED.
REQ-015 align_err  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-016 The FSM has two states: RUN and HALTED.
REQ-017 Capture condition: state=RUN, stall=0, branch_taken=0, and (out_valid=0 or out_ready=1).
REQ-018 On capture: out_instr<=instruction, out_pc<=pc, out_valid<=1, pc<=pc+4 modulo 1024 (1020 wraps to 0).
REQ-019 Fetch-to-output latency is one cycle: the word at address in cycle N is on out_instr in cycle N+1.
REQ-020 With out_valid&out_ready=1 and no capture, out_valid<=0 next cycle.
REQ-021 With out_valid=1 and out_ready=0, out_instr, out_pc and out_valid hold, and pc does not advance.
REQ-022 stall=1 freezes pc and blocks capture; a pending out_valid word can still be consumed.
REQ-023 branch_taken=1 has priority over stall, capture and HALTED. Next cycle: pc<=target, out_valid<=0 (flush), state<=RUN. That cycle's memory word is discarded.
REQ-024 A captured word equal to HALT_WORD is still delivered on out_instr. State<=HALTED on the same edge, and pc does not advance.
REQ-025 In HALTED: no capture; the pending output still drains. Exit occurs only via branch_taken or rst.
REQ-026 A branch_taken and out_ready in the same cycle: the flush wins and the word is treated as not accepted.

Reset
REQ-027 When rst=1 at a clock edge: pc<=RESET_PC, out_valid<=0, out_instr<=0, out_pc<=0, state<=RUN, align_err<=0.
REQ-028 rst has priority over all other inputs, including mid-handshake and in HALTED.
REQ-029 The first capture occurs in the first cycle after rst deasserts, subject to REQ-017.

Configuration
REQ-030 The macro FETCH_ALIGN_CHECK_EN controls alignment checking.
- Defined: branch_taken with branch_target[1:0]!=0 ignores the redirect (pc, state and out_valid unchanged) and sets align_err=1 until rst.
- Undefined: branch_target[1:0] is forced to 00 on redirect, and align_err is tied 0.

Verification (memory preloaded bytes 0..7 = 00 FF 55 0F CC 33 F0 92; all other bytes FF)
REQ-031 Release rst, out_ready=1 -> cycle 1 out_instr=32'h00FF550F, out_pc=0; cycle 2 32'hCC33F092, out_pc=4; cycle 3 32'hFFFFFFFF, out_pc=8, halted=1 on the same edge, address stays 8.
REQ-032 out_ready=0 after the first capture for 3 cycles -> out_valid=1 and out_instr=32'h00FF550F held, address=4 throughout; then out_ready=1 -> next word 32'hCC33F092.
REQ-033 In HALTED, pulse branch_taken with target 10'd4 -> out_valid=0 next cycle, halted=0, address=4; following cycle out_instr=32'hCC33F092.
REQ-034 Set pc to 1020 via redirect (memory 1020..1023 = 00 FF 55 0F) -> captured out_pc=1020, then address wraps to 0.
REQ-035 Assert stall and branch_taken (target 4) together, then assert rst mid-stream -> redirect taken despite stall; after rst, address=RESET_PC, out_valid=0, halted=0.
REQ-036 With FETCH_ALIGN_CHECK_EN, branch_target=10'd6 -> align_err=1 and pc unchanged; without it -> pc=4.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC fetch with one-entry output register, stall, redirect and halt.
// Optional macro FETCH_ALIGN_CHECK_EN: reject misaligned redirects and raise a sticky align_err.
module fetch_unit #(
    parameter logic [9:0]  RESET_PC  = 10'd0,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  address,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [9:0]  branch_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [9:0]  out_pc,
    output logic        halted,
    output logic        align_err
);

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_instr_q, out_instr_d;
    logic [AW-1:0]   out_pc_q, out_pc_d;
    logic            capture_c;
`ifdef FETCH_ALIGN_CHECK_EN
    logic            align_err_q, align_err_d;
`endif

    // A new word may enter the output register only when the slot is free or being drained.
    assign capture_c = (state_q == ST_RUN) && !stall && !branch_taken
                       && (!out_valid_q || out_ready);

    // Next-state logic: redirect beats everything, then capture, then drain.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
        align_err_d = align_err_q;
`endif
        if (branch_taken) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (branch_target[1:0] != 2'b00) begin
                align_err_d = 1'b1;
            end else begin
                pc_d        = branch_target;
                out_valid_d = 1'b0;
                state_d     = ST_RUN;
            end
`else
            pc_d        = branch_target & ~AW'(3);
            out_valid_d = 1'b0;
            state_d     = ST_RUN;
`endif
        end else if (capture_c) begin
            out_instr_d = instruction;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            // The halt word is delivered but fetch stops on it.
            if (instruction == HALT_WORD) begin
                state_d = ST_HALTED;
            end else begin
                pc_d = pc_q + AW'(4);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            align_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
            align_err_q <= align_err_d;
`endif
        end
    end

    assign address   = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign halted    = (state_q == ST_HALTED);
`ifdef FETCH_ALIGN_CHECK_EN
    assign align_err = align_err_q;
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a byte-addressed big-endian instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  address;
    logic [31:0] instruction;
    logic        stall;
    logic        branch_taken;
    logic [9:0]  branch_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [9:0]  out_pc;
    logic        halted;
    logic        align_err;

    logic [7:0]  mem [0:1023];
    int          checks = 0;
    int          errors = 0;

    localparam logic [31:0] W0   = 32'h00FF550F;
    localparam logic [31:0] W1   = 32'hCC33F092;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    fetch_unit dut (
        .clk(clk), .rst(rst), .address(address), .instruction(instruction),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .halted(halted), .align_err(align_err)
    );

    always #5 clk = ~clk;

    always_comb instruction = {mem[address], mem[address + 10'd1],
                               mem[address + 10'd2], mem[address + 10'd3]};

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; out_ready = 1'b1;
        tick(); tick();
        checks++; if (address !== 10'd0) begin errors++; $display("FAIL reset_address got %0d exp 0", address); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", out_instr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL reset_align got %b exp 0", align_err); end
    endtask

    task automatic test_sequential();
        rst = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_instr !== W0 || out_pc !== 10'd0 || out_valid !== 1'b1) begin errors++;
            $display("FAIL seq_c1 got %h/%0d/%b exp %h/0/1", out_instr, out_pc, out_valid, W0); end
        tick();
        checks++; if (out_instr !== W1 || out_pc !== 10'd4) begin errors++;
            $display("FAIL seq_c2 got %h/%0d exp %h/4", out_instr, out_pc, W1); end
        tick();
        checks++; if (out_instr !== HALT || out_pc !== 10'd8 || halted !== 1'b1 || address !== 10'd8) begin errors++;
            $display("FAIL seq_c3 got %h/%0d/h%b/a%0d exp %h/8/h1/a8", out_instr, out_pc, halted, address, HALT); end
        tick();
        checks++; if (halted !== 1'b1 || out_valid !== 1'b0 || address !== 10'd8) begin errors++;
            $display("FAIL halt_drain got h%b/v%b/a%0d exp h1/v0/a8", halted, out_valid, address); end
    endtask

    task automatic test_backpressure();
        rst = 1'b1; tick(); rst = 1'b0; out_ready = 1'b0;
        tick();
        checks++; if (out_instr !== W0 || out_valid !== 1'b1) begin errors++;
            $display("FAIL bp_first got %h/%b exp %h/1", out_instr, out_valid, W0); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_instr !== W0 || out_pc !== 10'd0 || address !== 10'd4) begin errors++;
                $display("FAIL bp_hold%0d got %b/%h/%0d/a%0d exp 1/%h/0/a4", i, out_valid, out_instr, out_pc, address, W0); end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_instr !== W1 || out_pc !== 10'd4) begin errors++;
            $display("FAIL bp_release got %h/%0d exp %h/4", out_instr, out_pc, W1); end
        tick();
        checks++; if (halted !== 1'b1 || out_instr !== HALT) begin errors++;
            $display("FAIL bp_halt got h%b/%h exp h1/%h", halted, out_instr, HALT); end
    endtask

    task automatic test_branch_halted();
        branch_taken = 1'b1; branch_target = 10'd4;
        tick();
        branch_taken = 1'b0;
        checks++; if (out_valid !== 1'b0 || halted !== 1'b0 || address !== 10'd4) begin errors++;
            $display("FAIL brh_redirect got v%b/h%b/a%0d exp v0/h0/a4", out_valid, halted, address); end
        tick();
        checks++; if (out_instr !== W1 || out_pc !== 10'd4 || out_valid !== 1'b1) begin errors++;
            $display("FAIL brh_fetch got %h/%0d/%b exp %h/4/1", out_instr, out_pc, out_valid, W1); end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_target = 10'd1020;
        tick();
        branch_taken = 1'b0;
        checks++; if (address !== 10'd1020 || out_valid !== 1'b0) begin errors++;
            $display("FAIL wrap_redirect got a%0d/v%b exp a1020/v0", address, out_valid); end
        tick();
        checks++; if (out_instr !== W0 || out_pc !== 10'd1020 || address !== 10'd0) begin errors++;
            $display("FAIL wrap_capture got %h/%0d/a%0d exp %h/1020/a0", out_instr, out_pc, address, W0); end
        tick();
        checks++; if (out_instr !== W0 || out_pc !== 10'd0 || address !== 10'd4) begin errors++;
            $display("FAIL wrap_next got %h/%0d/a%0d exp %h/0/a4", out_instr, out_pc, address, W0); end
    endtask

    task automatic test_stall_branch_reset();
        tick();
        checks++; if (out_instr !== W1 || address !== 10'd8) begin errors++;
            $display("FAIL sbr_pre got %h/a%0d exp %h/a8", out_instr, address, W1); end
        stall = 1'b1;
        tick();
        checks++; if (address !== 10'd8 || out_valid !== 1'b0) begin errors++;
            $display("FAIL sbr_stall got a%0d/v%b exp a8/v0", address, out_valid); end
        branch_taken = 1'b1; branch_target = 10'd4;
        tick();
        branch_taken = 1'b0;
        checks++; if (address !== 10'd4 || out_valid !== 1'b0) begin errors++;
            $display("FAIL sbr_redirect got a%0d/v%b exp a4/v0", address, out_valid); end
        tick();
        checks++; if (address !== 10'd4 || out_valid !== 1'b0) begin errors++;
            $display("FAIL sbr_frozen got a%0d/v%b exp a4/v0", address, out_valid); end
        stall = 1'b0; out_ready = 1'b0;
        tick();
        checks++; if (out_instr !== W1 || out_valid !== 1'b1 || address !== 10'd8) begin errors++;
            $display("FAIL sbr_resume got %h/%b/a%0d exp %h/1/a8", out_instr, out_valid, address, W1); end
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        checks++; if (address !== 10'd0 || out_valid !== 1'b0 || halted !== 1'b0) begin errors++;
            $display("FAIL sbr_reset got a%0d/v%b/h%b exp a0/v0/h0", address, out_valid, halted); end
    endtask

    task automatic test_flush_vs_ready();
        tick();
        checks++; if (out_instr !== W0 || out_valid !== 1'b1) begin errors++;
            $display("FAIL fvr_capture got %h/%b exp %h/1", out_instr, out_valid, W0); end
        branch_taken = 1'b1; branch_target = 10'd0;
        tick();
        branch_taken = 1'b0;
        checks++; if (out_valid !== 1'b0 || address !== 10'd0) begin errors++;
            $display("FAIL fvr_flush got v%b/a%0d exp v0/a0", out_valid, address); end
    endtask

    task automatic test_align();
        branch_taken = 1'b1; branch_target = 10'd6;
        tick();
        branch_taken = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        checks++; if (align_err !== 1'b1 || address !== 10'd0) begin errors++;
            $display("FAIL align_reject got e%b/a%0d exp e1/a0", align_err, address); end
`else
        checks++; if (align_err !== 1'b0 || address !== 10'd4 || out_valid !== 1'b0) begin errors++;
            $display("FAIL align_force got e%b/a%0d/v%b exp e0/a4/v0", align_err, address, out_valid); end
        tick();
        checks++; if (out_instr !== W1 || out_pc !== 10'd4) begin errors++;
            $display("FAIL align_fetch got %h/%0d exp %h/4", out_instr, out_pc, W1); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
        mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h55; mem[3] = 8'h0F;
        mem[4] = 8'hCC; mem[5] = 8'h33; mem[6] = 8'hF0; mem[7] = 8'h92;
        mem[1020] = 8'h00; mem[1021] = 8'hFF; mem[1022] = 8'h55; mem[1023] = 8'h0F;
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch_halted();
        test_wrap();
        test_stall_branch_reset();
        test_flush_vs_ready();
        test_align();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
